// File: rtl/debounce.sv
// Single-bit debouncer: synchronizes an asynchronous input, then only lets the
// registered output move to a new level once the synchronized input has held
// that level for CYCLES consecutive clocks. Shorter glitches are discarded.
module debounce #(
  parameter int unsigned CYCLES      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out
);

  localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_out;

  logic                   w_s;
  logic [CntW-1:0]        w_cnt_d;
  logic                   w_out_d;

  // Synchronizer chain: sig_in enters bit 0, the top bit is the only consumer-visible sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Next-state: a matching sample clears the run; a full run of differing samples flips the output.
  always_comb begin
    w_cnt_d = r_cnt;
    w_out_d = r_out;
    if (w_s == r_out) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntMax) begin
      w_out_d = w_s;
      w_cnt_d = '0;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_out <= RESET_VAL;
    end else begin
      r_cnt <= w_cnt_d;
      r_out <= w_out_d;
    end
  end

  assign sig_out = r_out;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: a window-based reference model checked every cycle plus
// hand-computed latency/glitch expectations.
module tb_debounce;

  localparam int unsigned Cyc  = 16;
  localparam int unsigned Sync = 2;

  logic clk;
  logic rst_n;
  logic sig_in;
  logic sig_out;

  int n_checks = 0;
  int n_errors = 0;

  debounce #(
    .CYCLES     (Cyc),
    .SYNC_STAGES(Sync),
    .RESET_VAL  (1'b0)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .sig_out(sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: s lags sig_in by Sync edges; output flips when the last
  // Cyc samples of s all differ from the current output.
  logic m_out;
  logic m_dly[Sync];
  logic m_win[$];

  initial begin
    logic s;
    logic all_diff;
    m_out = 1'b0;
    for (int k = 0; k < Sync; k++) m_dly[k] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_out = 1'b0;
        for (int k = 0; k < Sync; k++) m_dly[k] = 1'b0;
        m_win.delete();
      end else begin
        s = m_dly[Sync-1];
        for (int k = Sync - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
        m_dly[0] = sig_in;
        m_win.push_back(s);
        if (m_win.size() > Cyc) void'(m_win.pop_front());
        if (m_win.size() == Cyc) begin
          all_diff = 1'b1;
          foreach (m_win[k]) if (m_win[k] == m_out) all_diff = 1'b0;
          if (all_diff) begin
            m_out = s;
            m_win.delete();
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    n_checks++;
    if (sig_out !== m_out) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t sig_out=%b expected=%b", $time, sig_out, m_out);
    end
  end

  task automatic check_lit(input string name, input logic exp);
    n_checks++;
    if (sig_out !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t sig_out=%b expected=%b", name, $time, sig_out, exp);
    end
  endtask

  // Drive v (just after a falling edge) and let n rising edges pass.
  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_lit("reset_state", 1'b0);
    hold(1'b0, 4);

    // Low-state glitches of 0..15 cycles.
    for (int i = 0; i < 16; i++) begin
      hold(1'b1, i);
      hold(1'b0, 16 - i);
    end
    hold(1'b0, 4);
    check_lit("low_glitch_hold", 1'b0);

    // Rise: flips exactly at edge 18.
    hold(1'b1, 17);
    check_lit("rise_edge17", 1'b0);
    hold(1'b1, 1);
    check_lit("rise_edge18", 1'b1);
    hold(1'b1, 82);
    check_lit("rise_stable", 1'b1);

    // High-state glitches of 0..15 cycles.
    for (int i = 0; i < 16; i++) begin
      hold(1'b0, i);
      hold(1'b1, 16 - i);
    end
    hold(1'b1, 4);
    check_lit("high_glitch_hold", 1'b1);

    // Fall: flips exactly at edge 18.
    hold(1'b0, 17);
    check_lit("fall_edge17", 1'b1);
    hold(1'b0, 1);
    check_lit("fall_edge18", 1'b0);
    hold(1'b0, 82);
    check_lit("fall_stable", 1'b0);

    // Interrupted run: 15 high, 1 low, then high; flips on the 16th unbroken sample.
    hold(1'b1, 15);
    hold(1'b0, 1);
    hold(1'b1, 15);
    check_lit("interrupt_no_flip", 1'b0);
    hold(1'b1, 2);
    check_lit("interrupt_edge17", 1'b0);
    hold(1'b1, 1);
    check_lit("interrupt_flip", 1'b1);

    // Reset mid-count with counter at 10.
    hold(1'b0, 20);
    check_lit("pre_reset_low", 1'b0);
    hold(1'b1, 12);
    #2 rst_n = 1'b0;
    #1 check_lit("reset_midcount", 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 17);
    check_lit("post_reset_edge17", 1'b0);
    hold(1'b1, 1);
    check_lit("post_reset_edge18", 1'b1);

    // Asynchronous reset while output is high forces it low at once.
    hold(1'b1, 5);
    #2 rst_n = 1'b0;
    #1 check_lit("reset_from_high", 1'b0);
    @(negedge clk);
    sig_in = 1'b0;
    rst_n  = 1'b1;
    hold(1'b0, 30);
    check_lit("after_reset_low", 1'b0);

    // Toggle every cycle: output never moves.
    for (int i = 0; i < 40; i++) hold(i[0], 1);
    check_lit("toggle_hold", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
